// File: rtl/riscv_ex_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ex_muldiv_seq_if
// Description : EX-stage <-> multiply/divide sequencer signal bundle.
//               master = EX pipeline side, slave = muldiv sequencer side.
// Revision    : 1.0  initial release
// ============================================================================
interface riscv_ex_muldiv_seq_if #(
   parameter int MD_XLEN = 32
);
   logic               i_EX_md_req;
   logic [2:0]         i_EX_funct3;
   logic               i_EX_flush;
   logic [MD_XLEN-1:0] i_EX_rs1_data;
   logic [MD_XLEN-1:0] i_EX_rs2_data;
   logic               o_EX_stall;
   logic               o_EX_md_valid;
   logic [MD_XLEN-1:0] o_EX_md_out;
   logic               o_EX_md_busy;

   modport master (
      output i_EX_md_req, i_EX_funct3, i_EX_flush, i_EX_rs1_data, i_EX_rs2_data,
      input  o_EX_stall, o_EX_md_valid, o_EX_md_out, o_EX_md_busy
   );

   modport slave (
      input  i_EX_md_req, i_EX_funct3, i_EX_flush, i_EX_rs1_data, i_EX_rs2_data,
      output o_EX_stall, o_EX_md_valid, o_EX_md_out, o_EX_md_busy
   );
endinterface
`default_nettype wire

// File: rtl/riscv_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ex_muldiv_seq
// Description : RV32M multiply/divide sequencer for the EX stage. Stalls the
//               pipeline while a one-bit-per-cycle shift-add multiplier or
//               restoring divider runs on operand magnitudes, then applies the
//               sign fix and pulses o_EX_md_valid for one cycle.
//               Optional macro RISCV_MD_FAST_EN: trivial operations (operand
//               zero, divide by zero, signed overflow) skip the BUSY phase.
// Revision    : 1.0  initial release
// ============================================================================
module riscv_ex_muldiv_seq #(
   parameter int MD_XLEN = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   riscv_ex_muldiv_seq_if.slave  md
);

   localparam int CW = (MD_XLEN > 1) ? $clog2(MD_XLEN) : 1;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          count_q, count_d;
   logic [2*MD_XLEN-1:0]   acc_q,   acc_d;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
   logic [MD_XLEN-1:0]     opnd_q,  opnd_d;   // mul: |a| (addend); div: |b| (divisor)
   logic [2:0]             f3_q,    f3_d;
   logic                   sa_q,    sa_d;
   logic                   sb_q,    sb_d;
   logic                   dz_q,    dz_d;     // divisor was zero
   logic [MD_XLEN-1:0]     out_q,   out_d;

   logic                   a_signed, b_signed, a_neg, b_neg;
   logic [MD_XLEN-1:0]     a_mag, b_mag;

   logic [MD_XLEN:0]       mul_sum;
   logic [2*MD_XLEN-1:0]   mul_next;
   logic [MD_XLEN:0]       div_sh;
   logic [MD_XLEN:0]       div_diff;
   logic                   div_ge;
   logic [2*MD_XLEN-1:0]   div_next;
   logic [2*MD_XLEN-1:0]   step_acc;

   logic [2*MD_XLEN-1:0]   prod;
   logic [MD_XLEN-1:0]     quo, rem;
   logic [MD_XLEN-1:0]     final_res;

   logic                   stall, valid;

   // Operand decode: per-funct3 signedness and operand magnitudes.
   always_comb begin
      a_signed = (md.i_EX_funct3 == F3_MULH) || (md.i_EX_funct3 == F3_MULHSU) ||
                 (md.i_EX_funct3 == F3_DIV)  || (md.i_EX_funct3 == F3_REM);
      b_signed = (md.i_EX_funct3 == F3_MULH) || (md.i_EX_funct3 == F3_DIV) ||
                 (md.i_EX_funct3 == F3_REM);
      a_neg    = a_signed & md.i_EX_rs1_data[MD_XLEN-1];
      b_neg    = b_signed & md.i_EX_rs2_data[MD_XLEN-1];
      a_mag    = a_neg ? (~md.i_EX_rs1_data + 1'b1) : md.i_EX_rs1_data;
      b_mag    = b_neg ? (~md.i_EX_rs2_data + 1'b1) : md.i_EX_rs2_data;
   end

   // One iteration of the shift-add multiplier or restoring divider.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*MD_XLEN-1:MD_XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[MD_XLEN-1:1]};
      // Remainder shifted left with next dividend bit; compare rather than
      // borrow so a zero divisor cleanly yields all-ones / dividend.
      div_sh   = acc_q[2*MD_XLEN-1:MD_XLEN-1];
      div_ge   = (div_sh >= {1'b0, opnd_q});
      div_diff = div_sh - {1'b0, opnd_q};
      div_next = div_ge ? {div_diff[MD_XLEN-1:0], acc_q[MD_XLEN-2:0], 1'b1}
                        : {div_sh[MD_XLEN-1:0],   acc_q[MD_XLEN-2:0], 1'b0};
      step_acc = f3_q[2] ? div_next : mul_next;
   end

   // Sign fix and result selection from the final iteration's accumulator.
   always_comb begin
      prod = (sa_q ^ sb_q) ? (~step_acc + 1'b1) : step_acc;
      quo  = step_acc[MD_XLEN-1:0];
      rem  = step_acc[2*MD_XLEN-1:MD_XLEN];
      case (f3_q)
         F3_MUL:                       final_res = prod[MD_XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*MD_XLEN-1:MD_XLEN];
         F3_DIV, F3_DIVU:              final_res = dz_q ? '1 : ((sa_q ^ sb_q) ? (~quo + 1'b1) : quo);
         default:                      final_res = sa_q ? (~rem + 1'b1) : rem;
      endcase
   end

`ifdef RISCV_MD_FAST_EN
   logic               a_zero, b_zero, sovf, fast_hit;
   logic [MD_XLEN-1:0] fast_val;

   // Early-out detection and the trivial result it produces.
   always_comb begin
      a_zero   = (md.i_EX_rs1_data == '0);
      b_zero   = (md.i_EX_rs2_data == '0);
      sovf     = ((md.i_EX_funct3 == F3_DIV) || (md.i_EX_funct3 == F3_REM)) &&
                 (md.i_EX_rs1_data == {1'b1, {(MD_XLEN-1){1'b0}}}) &&
                 (md.i_EX_rs2_data == '1);
      fast_hit = a_zero | b_zero | sovf;
      fast_val = '0;
      if (md.i_EX_funct3[2]) begin
         if (b_zero)
            fast_val = md.i_EX_funct3[1] ? md.i_EX_rs1_data : '1;
         else if (sovf)
            fast_val = md.i_EX_funct3[1] ? '0 : md.i_EX_rs1_data;
      end
   end
`endif

   // Next-state, datapath load/iterate and handshake outputs.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      f3_d    = f3_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      out_d   = out_q;
      stall   = 1'b0;
      valid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (md.i_EX_md_req && !md.i_EX_flush) begin
               stall   = 1'b1;
               f3_d    = md.i_EX_funct3;
               sa_d    = a_neg;
               sb_d    = b_neg;
               dz_d    = (md.i_EX_rs2_data == '0);
               opnd_d  = md.i_EX_funct3[2] ? b_mag : a_mag;
               acc_d   = {{MD_XLEN{1'b0}}, (md.i_EX_funct3[2] ? a_mag : b_mag)};
               count_d = CW'(MD_XLEN - 1);
               state_d = ST_BUSY;
`ifdef RISCV_MD_FAST_EN
               if (fast_hit) begin
                  out_d   = fast_val;
                  state_d = ST_DONE;
               end
`endif
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (md.i_EX_flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc;
               if (count_q == '0) begin
                  out_d   = final_res;
                  state_d = ST_DONE;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
         ST_DONE: begin
            // Request still high here is the retiring instruction; never restart.
            valid   = ~md.i_EX_flush;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         f3_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         f3_q    <= f3_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         out_q   <= out_d;
      end
   end

   assign md.o_EX_stall    = stall;
   assign md.o_EX_md_valid = valid;
   assign md.o_EX_md_out   = out_q;
   assign md.o_EX_md_busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_riscv_ex_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_riscv_ex_muldiv_seq
// Description : Scoreboard bench for riscv_ex_muldiv_seq: directed RV32M
//               vectors, flush and asynchronous reset mid-operation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_ex_muldiv_seq;
   localparam int XL = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   riscv_ex_muldiv_seq_if #(.MD_XLEN(XL)) md_if ();
   riscv_ex_muldiv_seq #(.MD_XLEN(XL)) dut (.i_clk(clk), .i_rst(rst), .md(md_if));

   typedef struct {
      logic [31:0] val;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid pulse must match the oldest expected result and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (md_if.o_EX_md_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: cycle %0d out=%h, required no pulse", cyc, md_if.o_EX_md_out);
         end else begin
            e = sb_q.pop_front();
            if (md_if.o_EX_md_out !== e.val || cyc != e.cyc)
               begin
                  errors++;
                  $display("FAIL op%0d: out=%h at cycle %0d, required %h at cycle %0d",
                           e.id, md_if.o_EX_md_out, cyc, e.val, e.cyc);
               end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   function automatic int lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int l;
      l = 33;
`ifdef RISCV_MD_FAST_EN
      if (a == 32'd0 || b == 32'd0) l = 1;
      if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) l = 1;
`endif
      return l;
   endfunction

   // Issue one op (entered at posedge+1), hold req through DONE, then drop it.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int id);
      int l;
      bit got;
      l = lat(f3, a, b);
      md_if.i_EX_funct3   = f3;
      md_if.i_EX_rs1_data = a;
      md_if.i_EX_rs2_data = b;
      md_if.i_EX_md_req   = 1'b1;
      sb_q.push_back('{val: expv, cyc: cyc + l, id: id});
      #1 chk("stall_cycle0", {31'd0, md_if.o_EX_stall}, 32'd1);
      got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            md_if.i_EX_rs1_data = $urandom;
            md_if.i_EX_rs2_data = $urandom;
         end
         if (md_if.o_EX_md_valid) begin
            got = 1'b1;
            chk("stall_done", {31'd0, md_if.o_EX_stall}, 32'd0);
            chk("done_latency", 32'(i), 32'(l));
         end else begin
            chk("stall_busy", {31'd0, md_if.o_EX_stall}, 32'd1);
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout op%0d: no valid within 40 cycles, required at %0d", id, l);
      end
      @(posedge clk); #1;
      md_if.i_EX_md_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      md_if.i_EX_md_req   = 1'b0;
      md_if.i_EX_flush    = 1'b0;
      md_if.i_EX_funct3   = 3'b000;
      md_if.i_EX_rs1_data = '0;
      md_if.i_EX_rs2_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out",   md_if.o_EX_md_out, 32'd0);
      chk("reset_valid", {31'd0, md_if.o_EX_md_valid}, 32'd0);
      chk("reset_busy",  {31'd0, md_if.o_EX_md_busy}, 32'd0);
      chk("reset_stall", {31'd0, md_if.o_EX_stall}, 32'd0);
      md_if.i_EX_md_req = 1'b1;
      #1 chk("reset_stall_req", {31'd0, md_if.o_EX_stall}, 32'd1);
      md_if.i_EX_md_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);   // MUL 7*-3
      run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);   // MULHU
      run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 3);   // MULH
      run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 4);   // MULHSU -1*2
      run_op(3'b010, 32'd2,          32'h8000_0000, 32'h0000_0001, 5);   // MULHSU b unsigned
      run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 6);   // MULH -1*-1
      run_op(3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 7);   // DIV -20/3
      run_op(3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 8);   // REM -20%3
      run_op(3'b101, 32'd100,        32'd7,         32'd14,        9);   // DIVU
      run_op(3'b111, 32'd100,        32'd7,         32'd2,         10);  // REMU
      run_op(3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 11);  // DIV 7/-2
      run_op(3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         12);  // REM 7%-2
      run_op(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 13);  // DIV by zero
      run_op(3'b110, 32'd5,          32'd0,         32'd5,         14);  // REM by zero
      run_op(3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 15);  // REM -5 by zero
      run_op(3'b101, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 16);  // DIVU by zero
      run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 17);  // DIV overflow
      run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         18);  // REM overflow
      run_op(3'b000, 32'd0,          32'd12345,     32'd0,         19);  // MUL by zero

      // Flush during BUSY: no pulse, back to IDLE, next op runs normally.
      md_if.i_EX_funct3   = 3'b100;
      md_if.i_EX_rs1_data = 32'd100;
      md_if.i_EX_rs2_data = 32'd7;
      md_if.i_EX_md_req   = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      md_if.i_EX_flush = 1'b1;
      #1 chk("flush_stall_c10", {31'd0, md_if.o_EX_stall}, 32'd1);
      @(posedge clk); #1;
      md_if.i_EX_flush  = 1'b0;
      md_if.i_EX_md_req = 1'b0;
      chk("flush_busy_c11",  {31'd0, md_if.o_EX_md_busy}, 32'd0);
      chk("flush_stall_c11", {31'd0, md_if.o_EX_stall}, 32'd0);
      chk("flush_out_hold",  md_if.o_EX_md_out, 32'd0);
      @(posedge clk); #1;
      run_op(3'b000, 32'd6, 32'd7, 32'd42, 20);                         // MUL after flush

      // Asynchronous reset in the middle of a MULH.
      md_if.i_EX_funct3   = 3'b001;
      md_if.i_EX_rs1_data = 32'd3;
      md_if.i_EX_rs2_data = 32'd5;
      md_if.i_EX_md_req   = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_busy", {31'd0, md_if.o_EX_md_busy}, 32'd1);
      rst               = 1'b1;
      md_if.i_EX_md_req = 1'b0;
      #1;
      chk("mid_reset_out",   md_if.o_EX_md_out, 32'd0);
      chk("mid_reset_busy",  {31'd0, md_if.o_EX_md_busy}, 32'd0);
      chk("mid_reset_stall", {31'd0, md_if.o_EX_stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 21);  // MULH after reset
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_retrigger_busy", {31'd0, md_if.o_EX_md_busy}, 32'd0);
         chk("out_hold",          md_if.o_EX_md_out, 32'h4000_0000);
      end

      repeat (2) @(posedge clk);
      #1 chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
